// File: rtl/deser_pkg.sv
// ----------------------------------------------------------------------------
// deser_pkg
// Types and constants shared by the deserializer side and the receive queue
// controller.
//   DESER_DEPTH_DEFAULT : default receive queue capacity in bytes
//   hs_state_t          : byte handshake state (WAIT / ACK / HOLD)
// ----------------------------------------------------------------------------
package deser_pkg;

  localparam int DESER_DEPTH_DEFAULT = 8;

  // Fixed codes so older code that compares raw state bits keeps working.
  localparam logic [1:0] HS_WAIT_CODE = 2'b00;
  localparam logic [1:0] HS_ACK_CODE  = 2'b01;
  localparam logic [1:0] HS_HOLD_CODE = 2'b10;

  typedef enum logic [1:0] {
    HS_WAIT = HS_WAIT_CODE,
    HS_ACK  = HS_ACK_CODE,
    HS_HOLD = HS_HOLD_CODE
  } hs_state_t;

endpackage

// File: rtl/deser_queue_ctrl_byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
// Byte queue with first-word-fall-through head.
// Ports:
//   clock_100   : clock, rising edge
//   reset       : asynchronous active-high reset (pointers and count only)
//   i_push      : write i_push_data at the tail (ignored when full)
//   i_push_data : byte to write
//   i_pop       : drop the head byte (ignored when empty)
//   o_head      : oldest byte, 8'h00 while empty
//   o_len       : occupancy 0..DEPTH
//   o_full      : occupancy == DEPTH
//   o_empty     : occupancy == 0
// ----------------------------------------------------------------------------
module byte_fifo
  import deser_pkg::*;
#(
  parameter int DEPTH = DESER_DEPTH_DEFAULT
) (
  input  logic                     clock_100,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic [$clog2(DEPTH):0]   o_len,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LEN_FULL = (PW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_len;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_len == LEN_FULL);
  assign o_empty   = (r_len == '0);
  assign o_len     = r_len;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Head is read combinationally so the oldest byte is visible the cycle
  // after it is written; the array is small enough to live in LUT RAM.
  assign o_head = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  // Contents are not cleared by reset; only pointers/count define validity.
  always_ff @(posedge clock_100) begin
    if (!reset && w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_len <= r_len + 1'b1;
        2'b01:   r_len <= r_len - 1'b1;
        default: r_len <= r_len;
      endcase
    end
  end

endmodule

// File: rtl/deser_queue_ctrl.sv
// ----------------------------------------------------------------------------
// deser_queue_ctrl
// Accepts bytes from a deserializer with a ready/ack handshake and queues
// them for a consumer that pops one byte per cycle.
// Ports:
//   clock_100     : clock, rising edge
//   reset         : asynchronous active-high reset
//   data_ready_in : deserializer byte-complete flag
//   data_in       : deserializer byte
//   ack_out       : one-cycle acknowledge per accepted byte
//   deq_in        : consumer pop request
//   data_out      : queue head (first-word-fall-through), 8'h00 when empty
//   len_out       : occupancy 0..DEPTH
//   full_out      : occupancy == DEPTH
//   empty_out     : occupancy == 0
//   underflow_out : sticky, set by a pop request while empty
// ----------------------------------------------------------------------------
module deser_queue_ctrl
  import deser_pkg::*;
#(
  parameter int DEPTH = DESER_DEPTH_DEFAULT
) (
  input  logic                     clock_100,
  input  logic                     reset,
  input  logic                     data_ready_in,
  input  logic [7:0]               data_in,
  output logic                     ack_out,
  input  logic                     deq_in,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   len_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic                     underflow_out
);

  hs_state_t r_state;
  logic      r_ack;
  logic      r_underflow;
  logic      w_push;
  logic      w_full;
  logic      w_empty;

  // A full queue simply leaves the deserializer waiting in WAIT; the byte
  // stays on its outputs until a slot frees up.
  assign w_push = (r_state == HS_WAIT) && data_ready_in && !w_full;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_100   (clock_100),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (data_in),
    .i_pop       (deq_in),
    .o_head      (data_out),
    .o_len       (len_out),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) begin
      r_state <= HS_WAIT;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        HS_WAIT: begin
          if (w_push) begin
            r_ack   <= 1'b1;
            r_state <= HS_ACK;
          end else begin
            r_ack   <= 1'b0;
          end
        end
        HS_ACK: begin
          r_ack   <= 1'b0;
          r_state <= HS_HOLD;
        end
        HS_HOLD: begin
          // Ready may linger after the ack; wait for it to drop so the same
          // byte is never captured twice.
          r_ack <= 1'b0;
          if (!data_ready_in) r_state <= HS_WAIT;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= HS_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (deq_in && w_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign ack_out       = r_ack;
  assign full_out      = w_full;
  assign empty_out     = w_empty;
  assign underflow_out = r_underflow;

endmodule

// File: doc/deser_queue_ctrl.md
DESER_QUEUE_CTRL -- requirements
Module: deser_queue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue capacity in bytes (power of two, 2..16).
REQ-002 SHALL have port clock_100  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_ready_in  input  1  deserializer byte-complete flag.
REQ-005 SHALL have port data_in  input  8  deserializer parallel byte.
REQ-006 SHALL have port ack_out  output  1  acknowledge to deserializer ack input.
REQ-007 SHALL have port deq_in  input  1  consumer pop request, one byte per cycle.
REQ-008 SHALL have port data_out  output  8  queue head byte (first-word-fall-through).
REQ-009 SHALL have port len_out  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 SHALL have ports full_out, empty_out  output  1  occupancy==DEPTH, occupancy==0.
REQ-011 SHALL have port underflow_out  output  1  sticky flag, pop attempted while empty.

Function
REQ-012 SHALL run a handshake FSM with states WAIT, ACK, HOLD.
REQ-013 WAIT: if data_ready_in=1 and full_out=0, SHALL push data_in, set ack_out<=1, and go to ACK in the same edge.
REQ-014 WAIT: if data_ready_in=1 and full_out=1, SHALL stay in WAIT with ack_out=0 (backpressure; byte held by deserializer, never lost).
REQ-015 ACK: SHALL set ack_out<=0 and go to HOLD; ack_out is high for exactly one cycle per byte.
REQ-016 HOLD: SHALL return to WAIT only after it samples data_ready_in=0; no push in HOLD (prevents double capture).
REQ-017 Capture latency: a byte present when data_ready_in is sampled high in WAIT SHALL appear on data_out (if queue was empty) and in len_out on the next cycle.
REQ-018 data_out SHALL equal the oldest stored byte when empty_out=0, and 8'h00 when empty_out=1.
REQ-019 deq_in=1 with empty_out=0 SHALL remove the head at the edge; deq_in=1 with empty_out=1 SHALL be ignored and set underflow_out.
REQ-020 Simultaneous push and pop SHALL both occur; len_out unchanged; pointers both advance.
REQ-021 Pop while full SHALL free one slot; a waiting byte SHALL be accepted at the following WAIT evaluation (one cycle later).
REQ-022 Read/write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; len_out SHALL never exceed DEPTH nor go below 0.
REQ-023 underflow_out SHALL stay set until reset.
REQ-024 Illegal FSM encoding SHALL go to WAIT with ack_out=0.

Reset
REQ-025 Reset SHALL immediately force: state WAIT, ack_out=0, pointers 0, len_out=0, empty_out=1, full_out=0, data_out=8'h00, underflow_out=0.
REQ-026 Reset mid-handshake (ACK or HOLD) SHALL drop ack_out same instant; queued bytes are discarded; storage array contents need not be cleared.
REQ-027 After reset release, first push SHALL require a fresh data_ready_in sample in WAIT.

Structure
REQ-028 Handshake state typedef (WAIT/ACK/HOLD) and default DEPTH constant SHALL live in shared package deser_pkg, also used by deserializer-side code.
REQ-029 Storage, pointers and occupancy SHALL be a sub-module byte_fifo (push/pop/full/empty/len, FWFT head); FSM and flags stay in deser_queue_ctrl.

Verification
REQ-030 Single byte: data_ready_in=1, data_in=8'hA5 in WAIT -> ack_out high exactly 1 cycle, next cycle data_out=8'hA5, len_out=1, empty_out=0.
REQ-031 Fill: push 8 bytes 8'h01..8'h08 with no pops -> full_out=1, len_out=8; 9th byte 8'h09 held, ack_out stays 0.
REQ-032 Backpressure release: from REQ-031 state pulse deq_in 1 cycle -> data_out changes 8'h01->8'h02, 8'h09 acked next cycle, len_out returns to 8, drain order 02..09.
REQ-033 Concurrent: len_out=3, push 8'h3C with deq_in=1 same edge -> len_out stays 3, head advances, 8'h3C at tail.
REQ-034 Underflow: empty, deq_in=1 -> len_out=0, data_out=8'h00, underflow_out=1 and held after 10 idle cycles.
REQ-035 Reset mid-op: assert reset during ACK with len_out=5 -> ack_out=0 immediately, len_out=0, empty_out=1; next byte 8'h77 accepted normally.
